// File: rtl/fp_to_fixed_decoder.sv
// IEEE-754 single-precision to sign-magnitude fixed-point converter.
// The mantissa is shifted right one bit per cycle until the binary point lines up with FRAC_W.
module fp_to_fixed_decoder #(
    parameter int unsigned INT_W  = 5,
    parameter int unsigned FRAC_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       float_in,
    output logic              busy,
    output logic              done,
    output logic              sign_out,
    output logic [INT_W-1:0]  integer_out,
    output logic [FRAC_W-1:0] mantissa_out,
    output logic              overflow,
    output logic              underflow,
    output logic              invalid
);

    localparam int unsigned RES_W   = INT_W + FRAC_W;
    localparam int unsigned ACC_W   = 24;
    localparam int unsigned CNT_W   = 5;
    localparam logic [7:0]  EXP_OVF = 8'(127 + INT_W);
    localparam logic [7:0]  EXP_UNF = 8'(127 - FRAC_W);
    localparam logic [9:0]  N_BASE  = 10'(150 - FRAC_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_UNPACK,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         op_q, op_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sgn_q, sgn_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic                inv_q, inv_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                sign_out_q, sign_out_d;
    logic [INT_W-1:0]    int_q, int_d;
    logic [FRAC_W-1:0]   man_q, man_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                invalid_q, invalid_d;

    logic [7:0]          exp_c;
    logic [22:0]         frac_c;
    logic [CNT_W-1:0]    shift_c;

    assign exp_c   = op_q[30:23];
    assign frac_c  = op_q[22:0];
    // n = 23 - FRAC_W - (exp - 127); only used when the operand is in range, so 5 bits suffice
    assign shift_c = CNT_W'(N_BASE - {2'b00, exp_c});

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sgn_q       <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inv_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sign_out_q  <= 1'b0;
            int_q       <= '0;
            man_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            invalid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sgn_q       <= sgn_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            inv_q       <= inv_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sign_out_q  <= sign_out_d;
            int_q       <= int_d;
            man_q       <= man_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            invalid_q   <= invalid_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sgn_d       = sgn_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        inv_d       = inv_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        sign_out_d  = sign_out_q;
        int_d       = int_q;
        man_d       = man_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        invalid_d   = invalid_q;

        // busy spans the done pulse, so a start during that cycle is still refused
        if (done_q) begin
            busy_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start && !busy_q) begin
                    op_d    = float_in;
                    busy_d  = 1'b1;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                sgn_d   = op_q[31];
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                inv_d   = 1'b0;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = S_DONE;
                if (exp_c == 8'hFF) begin
                    if (frac_c != '0) begin
                        inv_d = 1'b1;
                        sgn_d = 1'b0;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (exp_c == 8'h00) begin
                    unf_d = (frac_c != '0);
                end else if (exp_c >= EXP_OVF) begin
                    ovf_d = 1'b1;
                end else if (exp_c < EXP_UNF) begin
                    unf_d = 1'b1;
                end else begin
                    acc_d = {1'b1, frac_c};
                    cnt_d = shift_c;
                    if (shift_c != '0) begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                acc_d = acc_q >> 1;
                cnt_d = CNT_W'(cnt_q - CNT_W'(1));
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d      = 1'b1;
                sign_out_d  = sgn_q;
                overflow_d  = ovf_q;
                underflow_d = unf_q;
                invalid_d   = inv_q;
                if (ovf_q) begin
                    int_d = '1;
                    man_d = '1;
                end else begin
                    int_d = acc_q[RES_W-1:FRAC_W];
                    man_d = acc_q[FRAC_W-1:0];
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign sign_out     = sign_out_q;
    assign integer_out  = int_q;
    assign mantissa_out = man_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign invalid      = invalid_q;

endmodule

// File: tb/tb_fp_to_fixed_decoder.sv
// Scoreboard bench for fp_to_fixed_decoder with directed float vectors (INT_W=5, FRAC_W=5).
module tb_fp_to_fixed_decoder;

    localparam int unsigned INT_W  = 5;
    localparam int unsigned FRAC_W = 5;

    typedef struct packed {
        logic              sign;
        logic [INT_W-1:0]  ip;
        logic [FRAC_W-1:0] fp;
        logic              ovf;
        logic              unf;
        logic              inv;
    } res_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [31:0]       float_in = '0;
    logic              busy;
    logic              done;
    logic              sign_out;
    logic [INT_W-1:0]  integer_out;
    logic [FRAC_W-1:0] mantissa_out;
    logic              overflow;
    logic              underflow;
    logic              invalid;

    fp_to_fixed_decoder #(.INT_W(INT_W), .FRAC_W(FRAC_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .float_in(float_in),
        .busy(busy), .done(done), .sign_out(sign_out), .integer_out(integer_out),
        .mantissa_out(mantissa_out), .overflow(overflow), .underflow(underflow),
        .invalid(invalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    res_t exp_q[$];
    int   t0_q[$];
    int   lat_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   done_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    endtask

    // Monitor: every done pulse is matched against the oldest expected result
    always @(negedge clk) begin
        if (rst_n && done) begin
            res_t a;
            done_seen++;
            a = '{sign_out, integer_out, mantissa_out, overflow, underflow, invalid};
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(a), 32'hFFFF_FFFF);
            end else begin
                res_t e;
                int   t0;
                int   lat;
                e   = exp_q.pop_front();
                t0  = t0_q.pop_front();
                lat = lat_q.pop_front();
                check("result", 32'(a), 32'(e));
                check("latency", 32'(cyc - t0), 32'(lat));
            end
        end
    end

    function automatic res_t mk(input logic s, input int ip, input int fp,
                                input logic o, input logic u, input logic i);
        mk = '{s, INT_W'(ip), FRAC_W'(fp), o, u, i};
    endfunction

    task automatic push_exp(input res_t e, input int lat);
        exp_q.push_back(e);
        t0_q.push_back(cyc + 1);
        lat_q.push_back(lat);
    endtask

    task automatic issue(input logic [31:0] f, input res_t e, input int lat);
        @(negedge clk);
        start    = 1'b1;
        float_in = f;
        push_exp(e, lat);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        #1;
        while (exp_q.size() != 0 && k < 60) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        t0_q.delete();
        lat_q.delete();
    endtask

    task automatic check_all_zero(input string name);
        check(name, {17'b0, busy, done, sign_out, integer_out, mantissa_out,
                     overflow, underflow, invalid}, 32'd0);
    endtask

    initial begin
        int k;
        int seen;

        #12;
        check_all_zero("reset_outputs");
        @(negedge clk);
        rst_n = 1'b1;

        issue(32'h41540000, mk(0, 13, 8, 0, 0, 0), 17);    drain();  // 13.25
        issue(32'hC0200000, mk(1, 2, 16, 0, 0, 0), 19);    drain();  // -2.5
        issue(32'h3D000000, mk(0, 0, 1, 0, 0, 0), 25);     drain();  // 2^-5
        issue(32'h41FFC000, mk(0, 31, 31, 0, 0, 0), 16);   drain();  // 31.96875
        issue(32'h42000000, mk(0, 31, 31, 1, 0, 0), 2);    drain();  // 32.0
        issue(32'h7F800000, mk(0, 31, 31, 1, 0, 0), 2);    drain();  // +inf
        issue(32'hC2000000, mk(1, 31, 31, 1, 0, 0), 2);    drain();  // -32.0
        issue(32'h3C23D70A, mk(0, 0, 0, 0, 1, 0), 2);      drain();  // 0.01
        issue(32'h00000001, mk(0, 0, 0, 0, 1, 0), 2);      drain();  // denormal
        issue(32'h7FC00000, mk(0, 0, 0, 0, 0, 1), 2);      drain();  // NaN
        issue(32'hFFC00000, mk(0, 0, 0, 0, 0, 1), 2);      drain();  // -NaN
        issue(32'h00000000, mk(0, 0, 0, 0, 0, 0), 2);      drain();  // +0
        issue(32'h80000000, mk(1, 0, 0, 0, 0, 0), 2);      drain();  // -0

        // start mid-SHIFT is dropped
        issue(32'h41540000, mk(0, 13, 8, 0, 0, 0), 17);
        repeat (4) @(negedge clk);
        check("busy_mid_shift", 32'(busy), 32'd1);
        start    = 1'b1;
        float_in = 32'h42000000;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (5) @(negedge clk);

        // start during the done cycle is dropped, start the cycle after is taken
        issue(32'hC0200000, mk(1, 2, 16, 0, 0, 0), 19);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 60);
        check("done_wait", 32'(done), 32'd1);
        #1;
        start    = 1'b1;
        float_in = 32'h42000000;
        @(negedge clk);
        float_in = 32'h3D000000;
        push_exp(mk(0, 0, 1, 0, 0, 0), 25);
        @(negedge clk);
        start = 1'b0;
        drain();
        check("result_hold", {26'b0, sign_out, integer_out}, 32'd0);
        check("mantissa_hold", 32'(mantissa_out), 32'd1);

        // reset mid-SHIFT clears everything and suppresses the pending done
        issue(32'h41540000, mk(0, 13, 8, 0, 0, 0), 17);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_shift");
        exp_q.delete();
        t0_q.delete();
        lat_q.delete();
        seen = done_seen;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("no_done_after_reset", 32'(done_seen - seen), 32'd0);
        issue(32'hC0200000, mk(1, 2, 16, 0, 0, 0), 19);    drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
